lcd_wave_display: RTL

- Pixel source for the RGB LCD timing generator in the FIR audio/LCD design.
- Captures H_DISP consecutive filtered audio samples into a ping-pong buffer.
- Answers the timing generator's data_req / pixel_xpos / pixel_ypos with RGB565 pixel_data one clock later, drawing grid plus a connected oscilloscope-style trace.
- Bank swap happens only at frame end, so a frame never shows a half-written capture.

---
 rtl/lcd_wave_display_if.sv | 23 ++
 rtl/lcd_wave_display.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/lcd_wave_display_if.sv
// Pixel-source bus between lcd_wave_display and its neighbours.
// The master modport is the sample source plus the LCD timing generator;
// the slave modport is the wave display itself.
interface lcd_wave_display_if;
   logic        sample_valid;
   logic [15:0] sample_data;
   logic        data_req;
   logic [10:0] pixel_xpos;
   logic [10:0] pixel_ypos;
   logic [15:0] pixel_data;
   logic        frame_swap;
   logic        capture_busy;

   modport master (
      output sample_valid, sample_data, data_req, pixel_xpos, pixel_ypos,
      input  pixel_data, frame_swap, capture_busy
   );

   modport slave (
      input  sample_valid, sample_data, data_req, pixel_xpos, pixel_ypos,
      output pixel_data, frame_swap, capture_busy
   );
endinterface

// File: rtl/lcd_wave_display.sv
// Oscilloscope-style pixel source for the RGB LCD timing generator.
// Captures H_DISP audio samples into one bank of a ping-pong buffer while the
// other bank is drawn as a connected trace over a grid. Banks swap only at
// frame end, so a frame never shows a half-written capture.
// Optional feature macro: WAVE_TRIG_EN (rising zero-crossing trigger in ARM).
module lcd_wave_display #(
   parameter int unsigned H_DISP     = 480,
   parameter int unsigned V_DISP     = 272,
   parameter int unsigned Y_CENTER   = 136,
   parameter int unsigned GRID_STEP  = 60,
   parameter logic [15:0] BG_COLOR   = 16'h0000,
   parameter logic [15:0] GRID_COLOR = 16'h4208,
   parameter logic [15:0] WAVE_COLOR = 16'h07E0
) (
   input logic              lcd_clk,
   input logic              sys_rst_n,
   lcd_wave_display_if.slave bus
);

   localparam int unsigned AW = $clog2(H_DISP);

   typedef enum logic [1:0] {StArm, StCapture, StDone} state_e;

   state_e            state_q;
   logic [AW-1:0]     wr_addr_q;
   logic              wr_bank_q;
   logic              rd_bank_q;
   logic              disp_valid_q;
   logic              frame_swap_q;
   logic              capture_busy_q;
   logic [15:0]       pixel_data_q;
   logic signed [10:0] prev_row_q;

   logic signed [7:0] mem [2][H_DISP];

   logic signed [7:0] s8;
   logic              frame_end;
   logic              wr_en;

   assign s8        = bus.sample_data[15:8];
   assign frame_end = bus.data_req && (bus.pixel_xpos == 11'(H_DISP - 1))
                      && (bus.pixel_ypos == 11'(V_DISP));

`ifdef WAVE_TRIG_EN
   localparam int unsigned CW = $clog2(H_DISP + 1);

   logic signed [7:0] last_s8_q;
   logic              have_last_q;
   logic [CW-1:0]     arm_cnt_q;
   logic              trig;

   // Rising zero crossing, or forced start once a full buffer's worth went by.
   assign trig = bus.sample_valid &&
                 ((have_last_q && (last_s8_q < 0) && (s8 >= 0)) ||
                  (arm_cnt_q == CW'(H_DISP)));
`endif

   // Write strobe: every sample in CAPTURE, plus the trigger sample in ARM.
   always_comb begin
      wr_en = (state_q == StCapture) && bus.sample_valid;
`ifdef WAVE_TRIG_EN
      if ((state_q == StArm) && trig) wr_en = 1'b1;
`endif
   end

   // Capture FSM, bank ownership and status outputs.
   always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q        <= StArm;
         wr_addr_q      <= '0;
         wr_bank_q      <= 1'b0;
         rd_bank_q      <= 1'b1;
         disp_valid_q   <= 1'b0;
         frame_swap_q   <= 1'b0;
         capture_busy_q <= 1'b0;
`ifdef WAVE_TRIG_EN
         last_s8_q      <= '0;
         have_last_q    <= 1'b0;
         arm_cnt_q      <= '0;
`endif
      end else begin
         frame_swap_q <= 1'b0;
         unique case (state_q)
            StArm: begin
               capture_busy_q <= 1'b1;
`ifdef WAVE_TRIG_EN
               if (bus.sample_valid) begin
                  if (trig) begin
                     // Trigger sample already went to address 0.
                     wr_addr_q <= AW'(1);
                     state_q   <= StCapture;
                  end else begin
                     last_s8_q   <= s8;
                     have_last_q <= 1'b1;
                     arm_cnt_q   <= arm_cnt_q + 1'b1;
                  end
               end
`else
               state_q <= StCapture;
`endif
            end
            StCapture: begin
               capture_busy_q <= 1'b1;
               if (bus.sample_valid) begin
                  if (wr_addr_q == AW'(H_DISP - 1)) begin
                     wr_addr_q      <= '0;
                     state_q        <= StDone;
                     capture_busy_q <= 1'b0;
                  end else begin
                     wr_addr_q <= wr_addr_q + 1'b1;
                  end
               end
            end
            StDone: begin
               capture_busy_q <= 1'b0;
               if (frame_end) begin
                  wr_bank_q      <= rd_bank_q;
                  rd_bank_q      <= wr_bank_q;
                  disp_valid_q   <= 1'b1;
                  frame_swap_q   <= 1'b1;
                  capture_busy_q <= 1'b1;
                  state_q        <= StArm;
`ifdef WAVE_TRIG_EN
                  have_last_q    <= 1'b0;
                  arm_cnt_q      <= '0;
`endif
               end
            end
            default: state_q <= StArm;
         endcase
      end
   end

   // Sample buffer write port; contents are deliberately not reset.
   always_ff @(posedge lcd_clk) begin
      if (wr_en) mem[wr_bank_q][wr_addr_q] <= s8;
   end

   logic signed [7:0]  rd_s8;
   logic signed [10:0] cur_row;
   logic signed [10:0] ref_row;
   logic signed [10:0] lo_row;
   logic signed [10:0] hi_row;
   logic signed [10:0] ypos_s;
   logic               on_wave;
   logic               on_grid;
   logic [15:0]        colour;

   // Buffer read feeds the colour logic directly, so the pixel_data register
   // is the single pipeline stage and latency stays at one cycle.
   always_comb begin
      rd_s8   = mem[rd_bank_q][bus.pixel_xpos[AW-1:0]];
      cur_row = $signed(11'(Y_CENTER)) - {{3{rd_s8[7]}}, rd_s8};
      ref_row = (bus.pixel_xpos == 11'd0) ? cur_row : prev_row_q;
      lo_row  = (ref_row < cur_row) ? ref_row : cur_row;
      hi_row  = (ref_row < cur_row) ? cur_row : ref_row;
      ypos_s  = $signed(bus.pixel_ypos);
      on_wave = disp_valid_q && (ypos_s >= lo_row) && (ypos_s <= hi_row);
      on_grid = (bus.pixel_ypos == 11'(Y_CENTER)) ||
                ((bus.pixel_xpos % 11'(GRID_STEP)) == 11'd0);
      if (on_wave)      colour = WAVE_COLOR;
      else if (on_grid) colour = GRID_COLOR;
      else              colour = BG_COLOR;
   end

   // Pixel output register; prev_row only advances on a real request.
   always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         pixel_data_q <= '0;
         prev_row_q   <= $signed(11'(Y_CENTER));
      end else if (bus.data_req) begin
         pixel_data_q <= colour;
         prev_row_q   <= cur_row;
      end else begin
         pixel_data_q <= '0;
      end
   end

   assign bus.pixel_data   = pixel_data_q;
   assign bus.frame_swap   = frame_swap_q;
   assign bus.capture_busy = capture_busy_q;

endmodule
